register_file_write_arbiter: RTL and testbench

REGISTER_FILE_WRITE_ARBITER -- requirements
Module: register_file_write_arbiter

---
 rtl/register_file_write_arbiter_pkg.sv | 18 +
 rtl/register_file_write_arbiter_rr_pick6.sv | 37 +++
 rtl/register_file_write_arbiter.sv | 99 +++++++++
 tb/tb_register_file_write_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter.
//   NUM_SRC  number of write sources (mux select codes 0..NUM_SRC-1)
//   SEL_W    width of the data-mux select / source index
//   ADDR_W   register-file address width
//   IDLE/WRITE  arbiter state encodings
package register_file_write_arbiter_pkg;

    localparam int unsigned NUM_SRC = 6;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned ADDR_W  = 4;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    // Last-granted value after reset, so source 0 is searched first.
    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_SRC - 1);

endpackage

// File: rtl/register_file_write_arbiter_rr_pick6.sv
// Round-robin picker over six requesters (purely combinational).
//   Req[5:0]   request vector, bit i = source i
//   Last[2:0]  most recently granted source (0..5)
//   Valid      at least one request present
//   Idx[2:0]   first requesting source after Last, wrapping modulo 6
module rr_pick6
    import register_file_write_arbiter_pkg::*;
(
    input  logic [NUM_SRC-1:0] Req,
    input  logic [SEL_W-1:0]   Last,
    output logic               Valid,
    output logic [SEL_W-1:0]   Idx
);

    // Out-of-range Last is treated as the reset value so Idx stays in 0..5.
    logic [SEL_W-1:0] last_c;
    assign last_c = (Last > LAST_RST) ? LAST_RST : Last;

    // Search offsets 1..6 from Last; the first hit wins.
    always_comb begin
        logic [SEL_W:0] cand;
        Valid = 1'b0;
        Idx   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            cand = {1'b0, last_c} + (SEL_W+1)'(k);
            if (cand >= (SEL_W+1)'(NUM_SRC)) begin
                cand = cand - (SEL_W+1)'(NUM_SRC);
            end
            if (!Valid && Req[SEL_W'(cand)]) begin
                Valid = 1'b1;
                Idx   = SEL_W'(cand);
            end
        end
    end

endmodule

// File: rtl/register_file_write_arbiter.sv
// Arbitrates six write sources onto one register-file write port.
// IDLE picks a requester round-robin and captures its address; WRITE
// issues the write (and the requester's Ack) on the first unstalled cycle.
//   CLK, Reset   clock (rising edge), async active-high reset
//   Req[5:0]     per-source write request
//   Addr[23:0]   per-source destination, Addr[4i+3:4i] for source i
//   Stall        register file busy, suppresses the write
//   RFWD[2:0]    data-mux select (registered)
//   RFWrite      register-file write enable (combinational)
//   RFWAddr[3:0] register-file write address (registered)
//   Ack[5:0]     one-hot write-complete strobe (combinational)
//   Busy         state is WRITE (registered)
module register_file_write_arbiter
    import register_file_write_arbiter_pkg::*;
(
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [NUM_SRC-1:0]        Req,
    input  logic [NUM_SRC*ADDR_W-1:0] Addr,
    input  logic                      Stall,
    output logic [SEL_W-1:0]          RFWD,
    output logic                      RFWrite,
    output logic [ADDR_W-1:0]         RFWAddr,
    output logic [NUM_SRC-1:0]        Ack,
    output logic                      Busy
);

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [SEL_W-1:0]  last;
    logic [SEL_W-1:0]  last_nxt;
    logic [SEL_W-1:0]  rfwd_nxt;
    logic [ADDR_W-1:0] rfwaddr_nxt;
    logic              pick_valid;
    logic [SEL_W-1:0]  pick_idx;
    logic              write_go;

    rr_pick6 u_pick (
        .Req   (Req),
        .Last  (last),
        .Valid (pick_valid),
        .Idx   (pick_idx)
    );

    // State and datapath registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            RFWD    <= '0;
            RFWAddr <= '0;
            last    <= LAST_RST;
        end else begin
            state   <= state_nxt;
            RFWD    <= rfwd_nxt;
            RFWAddr <= rfwaddr_nxt;
            last    <= last_nxt;
        end
    end

    // Next-state: arbitrate only in IDLE; a grant holds until written.
    always_comb begin
        state_nxt   = state;
        rfwd_nxt    = RFWD;
        rfwaddr_nxt = RFWAddr;
        last_nxt    = last;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt   = WRITE;
                    rfwd_nxt    = pick_idx;
                    rfwaddr_nxt = Addr[pick_idx*ADDR_W +: ADDR_W];
                end
            end
            WRITE: begin
                if (!Stall) begin
                    state_nxt = IDLE;
                    last_nxt  = RFWD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Reset also gates the write so an in-flight write aborts at once.
    assign write_go = (state == WRITE) && !Stall && !Reset;
    assign RFWrite  = write_go;
    assign Busy     = (state == WRITE);

    // Ack mirrors RFWrite on the granted source only.
    always_comb begin
        Ack = '0;
        if (write_go) begin
            Ack[RFWD] = 1'b1;
        end
    end

endmodule

// File: tb/tb_register_file_write_arbiter.sv
module tb_register_file_write_arbiter;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [5:0]  Req = '0;
    logic [23:0] Addr = '0;
    logic        Stall = 1'b0;
    logic [2:0]  RFWD;
    logic        RFWrite;
    logic [3:0]  RFWAddr;
    logic [5:0]  Ack;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    // Reference model: an outstanding grant (source, address) or none.
    bit m_busy;
    int m_sel;
    int m_addr;
    int m_last;

    register_file_write_arbiter dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .Req     (Req),
        .Addr    (Addr),
        .Stall   (Stall),
        .RFWD    (RFWD),
        .RFWrite (RFWrite),
        .RFWAddr (RFWAddr),
        .Ack     (Ack),
        .Busy    (Busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    task automatic model_reset();
        m_busy = 0;
        m_sel  = 0;
        m_addr = 0;
        m_last = 5;
    endtask

    // One clock edge of the spec-level behaviour.
    task automatic model_edge();
        if (Reset) begin
            model_reset();
        end else if (m_busy) begin
            if (!Stall) begin
                m_last = m_sel;
                m_busy = 0;
            end
        end else begin
            for (int k = 1; k <= 6; k++) begin
                int c;
                c = (m_last + k) % 6;
                if (Req[c]) begin
                    m_sel  = c;
                    m_addr = (Addr >> (4 * c)) & 15;
                    m_busy = 1;
                    break;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Req   = '0;
        Addr  = '0;
        Stall = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Req   = 6'h3F;
        Addr  = 24'($urandom);
        #3;
        checks++; if (RFWD !== 3'd0)    begin errors++; $display("FAIL reset_rfwd got %0d exp 0", RFWD); end
        checks++; if (RFWAddr !== 4'd0) begin errors++; $display("FAIL reset_rfwaddr got %0h exp 0", RFWAddr); end
        checks++; if (RFWrite !== 1'b0) begin errors++; $display("FAIL reset_rfwrite got %b exp 0", RFWrite); end
        checks++; if (Ack !== 6'd0)     begin errors++; $display("FAIL reset_ack got %b exp 0", Ack); end
        checks++; if (Busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", Busy); end
        tick();
        checks++; if (Busy !== 1'b0 || RFWD !== 3'd0) begin errors++; $display("FAIL reset_hold busy=%b rfwd=%0d exp 0/0", Busy, RFWD); end
        Req = '0;
        Reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        Req  = 6'b000100;
        Addr = 24'h000A00;
        @(negedge CLK);
        checks++; if (Busy !== 1'b0 || RFWrite !== 1'b0) begin errors++; $display("FAIL single_c0 busy=%b rfwrite=%b exp 0/0", Busy, RFWrite); end
        tick();
        @(negedge CLK);
        checks++; if (RFWD !== 3'd2)       begin errors++; $display("FAIL single_rfwd got %0d exp 2", RFWD); end
        checks++; if (RFWAddr !== 4'hA)    begin errors++; $display("FAIL single_rfwaddr got %0h exp a", RFWAddr); end
        checks++; if (RFWrite !== 1'b1)    begin errors++; $display("FAIL single_rfwrite got %b exp 1", RFWrite); end
        checks++; if (Ack !== 6'b000100)   begin errors++; $display("FAIL single_ack got %b exp 000100", Ack); end
        checks++; if (Busy !== 1'b1)       begin errors++; $display("FAIL single_busy got %b exp 1", Busy); end
        tick();
        Req = '0;
        @(negedge CLK);
        checks++; if (Busy !== 1'b0 || RFWrite !== 1'b0 || RFWD !== 3'd2) begin
            errors++; $display("FAIL single_after busy=%b rfwrite=%b rfwd=%0d exp 0/0/2", Busy, RFWrite, RFWD);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int order[$];
        int when[$];
        int last_ack[6];
        int exp_order[7] = '{0, 1, 2, 3, 4, 5, 0};
        do_reset();
        foreach (last_ack[i]) last_ack[i] = -10;
        Req  = 6'h3F;
        Addr = 24'h543210;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge CLK);
            for (int i = 0; i < 6; i++) begin
                if (Ack[i]) begin
                    order.push_back(i);
                    when.push_back(cyc);
                    last_ack[i] = cyc;
                end
            end
            tick();
            for (int i = 0; i < 6; i++) begin
                if (last_ack[i] == cyc)          Req[i] = 1'b0;
                else if (last_ack[i] == cyc - 1) Req[i] = 1'b1;
            end
        end
        Req = '0;
        tick();
        tick();
        checks++; if (order.size() != 7) begin errors++; $display("FAIL rr_count got %0d acks exp 7", order.size()); end
        for (int n = 0; n < 7 && n < order.size(); n++) begin
            checks++; if (order[n] != exp_order[n]) begin errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", n, order[n], exp_order[n]); end
            checks++; if (when[n] != 2 * n + 1) begin errors++; $display("FAIL rr_cycle[%0d] got %0d exp %0d", n, when[n], 2 * n + 1); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        Req   = 6'b001000;
        Addr  = 24'h007000;
        Stall = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checks++; if (RFWrite !== 1'b0 || Ack !== 6'd0) begin errors++; $display("FAIL stall_nowrite[%0d] rfwrite=%b ack=%b exp 0/0", i, RFWrite, Ack); end
            checks++; if (RFWD !== 3'd3 || RFWAddr !== 4'h7 || Busy !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d] rfwd=%0d addr=%0h busy=%b exp 3/7/1", i, RFWD, RFWAddr, Busy);
            end
            tick();
        end
        Stall = 1'b0;
        @(negedge CLK);
        checks++; if (RFWrite !== 1'b1 || Ack !== 6'b001000) begin errors++; $display("FAIL stall_release rfwrite=%b ack=%b exp 1/001000", RFWrite, Ack); end
        tick();
        Req = '0;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        Req = 6'b010000;
        tick();
        @(negedge CLK);
        checks++; if (RFWD !== 3'd4 || RFWrite !== 1'b1) begin errors++; $display("FAIL wrap_setup rfwd=%0d rfwrite=%b exp 4/1", RFWD, RFWrite); end
        tick();
        Req = 6'b000011;
        tick();
        @(negedge CLK);
        checks++; if (RFWD !== 3'd0 || Ack !== 6'b000001) begin errors++; $display("FAIL wrap_first rfwd=%0d ack=%b exp 0/000001", RFWD, Ack); end
        tick();
        Req = 6'b000010;
        tick();
        @(negedge CLK);
        checks++; if (RFWD !== 3'd1 || Ack !== 6'b000010) begin errors++; $display("FAIL wrap_second rfwd=%0d ack=%b exp 1/000010", RFWD, Ack); end
        tick();
        Req = '0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        Req  = 6'b000001;
        Addr = 24'h000003;
        tick();
        #1;
        checks++; if (RFWrite !== 1'b1) begin errors++; $display("FAIL midrst_pre rfwrite got %b exp 1", RFWrite); end
        Reset = 1'b1;
        model_reset();
        #1;
        checks++; if (RFWrite !== 1'b0 || Ack !== 6'd0) begin errors++; $display("FAIL midrst_abort rfwrite=%b ack=%b exp 0/0", RFWrite, Ack); end
        checks++; if (Busy !== 1'b0 || RFWD !== 3'd0)   begin errors++; $display("FAIL midrst_state busy=%b rfwd=%0d exp 0/0", Busy, RFWD); end
        tick();
        Reset = 1'b0;
        Req   = '0;
        @(negedge CLK);
        checks++; if (Busy !== 1'b0 || RFWD !== 3'd0 || RFWAddr !== 4'd0 || Ack !== 6'd0) begin
            errors++; $display("FAIL midrst_after busy=%b rfwd=%0d addr=%0h ack=%b exp 0/0/0/0", Busy, RFWD, RFWAddr, Ack);
        end
        tick();
    endtask

    task automatic test_late_change();
        do_reset();
        Req  = 6'b000001;
        Addr = 24'h000005;
        tick();
        Addr = 24'h000009;
        @(negedge CLK);
        checks++; if (RFWAddr !== 4'h5 || RFWrite !== 1'b1 || Ack !== 6'b000001) begin
            errors++; $display("FAIL late_change addr=%0h rfwrite=%b ack=%b exp 5/1/000001", RFWAddr, RFWrite, Ack);
        end
        tick();
        Req = '0;
        tick();
    endtask

    task automatic test_random();
        bit         acked_prev[6];
        int         wait_cnt[6];
        logic       ew;
        logic [5:0] ea;
        do_reset();
        foreach (wait_cnt[i]) begin wait_cnt[i] = 0; acked_prev[i] = 0; end
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge CLK);
            ew = m_busy && !Stall;
            ea = ew ? 6'(1 << m_sel) : 6'd0;
            checks++; if (RFWD !== 3'(m_sel))    begin errors++; $display("FAIL rand_rfwd c%0d got %0d exp %0d", cyc, RFWD, m_sel); end
            checks++; if (RFWAddr !== 4'(m_addr)) begin errors++; $display("FAIL rand_rfwaddr c%0d got %0h exp %0h", cyc, RFWAddr, m_addr); end
            checks++; if (RFWrite !== ew)        begin errors++; $display("FAIL rand_rfwrite c%0d got %b exp %b", cyc, RFWrite, ew); end
            checks++; if (Ack !== ea)            begin errors++; $display("FAIL rand_ack c%0d got %b exp %b", cyc, Ack, ea); end
            checks++; if (Busy !== m_busy)       begin errors++; $display("FAIL rand_busy c%0d got %b exp %b", cyc, Busy, m_busy); end
            checks++; if (RFWD > 3'd5 || !$onehot0(Ack) || RFWrite !== |Ack) begin
                errors++; $display("FAIL rand_invariant c%0d rfwd=%0d ack=%b rfwrite=%b exp rfwd<=5, onehot0, rfwrite=|ack", cyc, RFWD, Ack, RFWrite);
            end
            if (ew) begin
                checks++; if (wait_cnt[m_sel] > 5) begin errors++; $display("FAIL rand_starve src%0d waited %0d grants exp <=5", m_sel, wait_cnt[m_sel]); end
                wait_cnt[m_sel] = 0;
                for (int i = 0; i < 6; i++) begin
                    if (i != m_sel && Req[i]) wait_cnt[i]++;
                end
            end
            tick();
            Stall = ($urandom % 4) == 0;
            for (int i = 0; i < 6; i++) begin
                if (acked_prev[i]) begin
                    Req[i] = 1'b0;
                end else if (!Req[i]) begin
                    Addr[i*4 +: 4] = 4'($urandom);
                    if ($urandom % 3 == 0) Req[i] = 1'b1;
                end
                acked_prev[i] = ea[i];
            end
        end
        Req   = '0;
        Stall = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_wrap();
        test_reset_mid_write();
        test_late_change();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
